// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read arbiter: one burst outstanding, fixed or round-robin priority.
// Optional feature: define AXI_ARB_ROUND_ROBIN_EN to rotate priority on each address handshake.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module axi_read_arbiter #(
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [`AXI_ID_BITS-1:0]   M0_ARID,
  input  logic [`AXI_ADDR_BITS-1:0] M0_ARAddr,
  input  logic [`AXI_LEN_BITS-1:0]  M0_ARLen,
  input  logic [`AXI_SIZE_BITS-1:0] M0_ARSize,
  input  logic [1:0]                M0_ARBurst,
  input  logic                      M0_ARValid,
  output logic                      M0_ARReady,
  input  logic [`AXI_ID_BITS-1:0]   M1_ARID,
  input  logic [`AXI_ADDR_BITS-1:0] M1_ARAddr,
  input  logic [`AXI_LEN_BITS-1:0]  M1_ARLen,
  input  logic [`AXI_SIZE_BITS-1:0] M1_ARSize,
  input  logic [1:0]                M1_ARBurst,
  input  logic                      M1_ARValid,
  output logic                      M1_ARReady,
  output logic [`AXI_IDS_BITS-1:0]  S_ARID,
  output logic [`AXI_ADDR_BITS-1:0] S_ARAddr,
  output logic [`AXI_LEN_BITS-1:0]  S_ARLen,
  output logic [`AXI_SIZE_BITS-1:0] S_ARSize,
  output logic [1:0]                S_ARBurst,
  output logic                      S_ARValid,
  input  logic                      S_ARReady,
  input  logic [`AXI_IDS_BITS-1:0]  S_RID,
  input  logic [`AXI_DATA_BITS-1:0] S_RData,
  input  logic [1:0]                S_RResp,
  input  logic                      S_RLast,
  input  logic                      S_RValid,
  output logic                      S_RReady,
  output logic [`AXI_ID_BITS-1:0]   M0_RID,
  output logic [`AXI_DATA_BITS-1:0] M0_RData,
  output logic [1:0]                M0_RResp,
  output logic                      M0_RLast,
  output logic                      M0_RValid,
  input  logic                      M0_RReady,
  output logic [`AXI_ID_BITS-1:0]   M1_RID,
  output logic [`AXI_DATA_BITS-1:0] M1_RData,
  output logic [1:0]                M1_RResp,
  output logic                      M1_RLast,
  output logic                      M1_RValid,
  input  logic                      M1_RReady,
  output logic [1:0]                dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a source keeps valid and its payload stable until that edge, ready may depend on valid.

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t                    state;
  logic                      grant;
  logic                      prio;
  logic                      pick;
  logic                      run;
  logic                      in_addr;
  logic                      in_data;
  logic [`AXI_ID_BITS-1:0]   ar_id;
  logic [`AXI_ADDR_BITS-1:0] ar_addr;
  logic [`AXI_LEN_BITS-1:0]  ar_len;
  logic [`AXI_SIZE_BITS-1:0] ar_size;
  logic [1:0]                ar_burst;
  logic                      unused_rid_hi;

  always_comb begin
    pick = M1_ARValid;
    if (M0_ARValid && M1_ARValid) pick = prio;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      grant    <= 1'b0;
      prio     <= INIT_PRIO;
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (M0_ARValid || M1_ARValid) begin
            grant    <= pick;
            ar_id    <= pick ? M1_ARID    : M0_ARID;
            ar_addr  <= pick ? M1_ARAddr  : M0_ARAddr;
            ar_len   <= pick ? M1_ARLen   : M0_ARLen;
            ar_size  <= pick ? M1_ARSize  : M0_ARSize;
            ar_burst <= pick ? M1_ARBurst : M0_ARBurst;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (S_ARReady) begin
            state <= DATA;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            prio  <= ~grant;
`endif
          end
        end
        DATA: begin
          // Burst end is taken from RLast alone; ARLen is never counted.
          if (S_RValid && S_RReady && S_RLast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset also masks every valid/ready combinationally, not only from the next edge.
  assign run     = !ARESET;
  assign in_addr = run && (state == ADDR);
  assign in_data = run && (state == DATA);

  assign S_ARValid  = in_addr;
  assign S_ARID     = `AXI_IDS_BITS'({4'(grant), ar_id});
  assign S_ARAddr   = ar_addr;
  assign S_ARLen    = ar_len;
  assign S_ARSize   = ar_size;
  assign S_ARBurst  = ar_burst;
  assign M0_ARReady = in_addr && !grant && S_ARReady;
  assign M1_ARReady = in_addr &&  grant && S_ARReady;

  assign S_RReady  = in_data && (grant ? M1_RReady : M0_RReady);
  assign M0_RValid = in_data && !grant && S_RValid;
  assign M1_RValid = in_data &&  grant && S_RValid;
  assign M0_RID    = S_RID[`AXI_ID_BITS-1:0];
  assign M1_RID    = S_RID[`AXI_ID_BITS-1:0];
  assign M0_RData  = S_RData;
  assign M1_RData  = S_RData;
  assign M0_RResp  = S_RResp;
  assign M1_RResp  = S_RResp;
  assign M0_RLast  = S_RLast;
  assign M1_RLast  = S_RLast;

  assign unused_rid_hi = ^S_RID[`AXI_IDS_BITS-1:`AXI_ID_BITS];
  assign dbg_state     = state;

endmodule
